// File: rtl/spi_pkg.sv
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared state encoding, reset constants and sizing helper for the
//           SPI receive path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_shift = 2'd1;
   localparam logic [1:0] c_st_push  = 2'd2;

   localparam logic SPI_SYNC_RESET_CEB = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = c_st_idle,
      SHIFT = c_st_shift,
      PUSH  = c_st_push
   } state_t;

   // Ceiling log2; clogb2(1) = 0.
   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rx_fifo.sv
// ============================================================================
// Module  : spi_rx_fifo
// Purpose : Small register FIFO with a registered head word for the SPI
//           receiver; a pop when full makes room for a same-cycle push.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rx_fifo
   import spi_pkg::*;
#(
   parameter int sword      = 32,
   parameter int fifo_depth = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [sword-1:0] push_data,
   input  logic             pop,
   output logic [sword-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int c_aw = clogb2(fifo_depth);

   logic [sword-1:0] r_mem [fifo_depth];
   logic [c_aw:0]    r_wr_ptr;
   logic [c_aw:0]    r_rd_ptr;
   logic [sword-1:0] r_head;
   logic [c_aw:0]    w_rd_next;
   logic [sword-1:0] w_head_next;
   logic             w_wr_en;
   logic             w_rd_en;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                  (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

   assign w_rd_en   = pop && !empty;
   assign w_wr_en   = push && (!full || w_rd_en);
   assign w_rd_next = r_rd_ptr + {{c_aw{1'b0}}, w_rd_en};

   // The head register tracks whatever entry will sit at the read pointer
   // after this cycle; a word written into that slot right now is forwarded.
   always_comb begin
      w_head_next = r_head;
      if (w_wr_en && (w_rd_next == r_wr_ptr)) begin
         w_head_next = push_data;
      end else if (w_rd_next != r_wr_ptr) begin
         w_head_next = r_mem[w_rd_next[c_aw-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_head   <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + {{c_aw{1'b0}}, 1'b1};
         end
         r_rd_ptr <= w_rd_next;
         r_head   <= w_head_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
      end
   end

   assign head_data = r_head;

endmodule

`default_nettype wire

// File: rtl/spi_rx_deserializer.sv
// ============================================================================
// Module  : spi_rx_deserializer
// Purpose : Oversampling SPI receiver: synchronizes CEB/SCLK/DATA, assembles
//           MSB-first words and queues them on a valid/ready stream.
//           Optional macro SPI_RX_STATUS_EN adds ovf_count / ferr_count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rx_deserializer
   import spi_pkg::*;
#(
   parameter int sword       = 32,
   parameter int fifo_depth  = 4,
   parameter int sync_stages = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CEB,
   input  logic             SCLK,
   input  logic             DATA,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [sword-1:0] out_data,
   output logic             busy,
   output logic             frame_err,
   output logic             overflow,
   input  logic             clr_status
`ifdef SPI_RX_STATUS_EN
   ,
   output logic [7:0]       ovf_count,
   output logic [7:0]       ferr_count
`endif
);

   localparam int                 c_cnt_w    = clogb2(sword + 1);
   localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(sword - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic [sync_stages-1:0] r_ceb_sync;
   logic [sync_stages-1:0] r_sclk_sync;
   logic [sync_stages-1:0] r_data_sync;
   logic                   r_sclk_prev;
   logic                   w_ceb_s;
   logic                   w_sclk_s;
   logic                   w_data_s;
   logic                   w_sclk_rise;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [c_cnt_w-1:0]     r_bit_cnt;
   logic [c_cnt_w-1:0]     w_bit_cnt_next;
   logic [sword-1:0]       r_shreg;
   logic [sword-1:0]       w_shreg_next;
   logic                   r_armed;
   logic                   w_armed_next;
   logic                   w_abort;
   logic                   w_push;
   logic                   r_frame_err;
   logic                   r_overflow;

   logic                   w_pop;
   logic                   w_drop;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ceb_sync  <= {sync_stages{SPI_SYNC_RESET_CEB}};
         r_sclk_sync <= '0;
         r_data_sync <= '0;
         r_sclk_prev <= 1'b0;
      end else begin
         r_ceb_sync  <= {r_ceb_sync[sync_stages-2:0], CEB};
         r_sclk_sync <= {r_sclk_sync[sync_stages-2:0], SCLK};
         r_data_sync <= {r_data_sync[sync_stages-2:0], DATA};
         r_sclk_prev <= w_sclk_s;
      end
   end

   assign w_ceb_s     = r_ceb_sync[sync_stages-1];
   assign w_sclk_s    = r_sclk_sync[sync_stages-1];
   assign w_data_s    = r_data_sync[sync_stages-1];
   assign w_sclk_rise = w_sclk_s && !r_sclk_prev;

   // r_armed records that CEB has been high since the last completed word,
   // so a chip enable held low after PUSH cannot start a second frame.
   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_shreg_next   = r_shreg;
      w_armed_next   = r_armed || w_ceb_s;
      w_abort        = 1'b0;
      w_push         = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_ceb_s && r_armed) begin
               w_state_next   = SHIFT;
               w_bit_cnt_next = '0;
               w_shreg_next   = '0;
            end
         end
         SHIFT: begin
            if (w_ceb_s) begin
               w_abort      = 1'b1;
               w_state_next = IDLE;
            end else if (w_sclk_rise) begin
               w_shreg_next   = {r_shreg[sword-2:0], w_data_s};
               w_bit_cnt_next = r_bit_cnt + c_cnt_one;
               if (r_bit_cnt == c_last_bit) begin
                  w_state_next = PUSH;
               end
            end
         end
         PUSH: begin
            w_push       = 1'b1;
            w_state_next = IDLE;
            w_armed_next = w_ceb_s;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_pop  = out_valid && out_ready;
   assign w_drop = w_push && w_fifo_full && !w_pop;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_armed     <= 1'b1;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_shreg     <= w_shreg_next;
         r_armed     <= w_armed_next;
         r_frame_err <= w_abort;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_status) begin
            r_overflow <= 1'b0;
         end
      end
   end

   spi_rx_fifo #(
      .sword      (sword),
      .fifo_depth (fifo_depth)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (w_push),
      .push_data (r_shreg),
      .pop       (w_pop),
      .head_data (out_data),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   assign out_valid = !w_fifo_empty;
   assign busy      = (r_state != IDLE);
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

`ifdef SPI_RX_STATUS_EN
   logic [7:0] r_ovf_count;
   logic [7:0] r_ferr_count;

   // A clear coinciding with an event leaves the event counted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ovf_count  <= 8'd0;
         r_ferr_count <= 8'd0;
      end else begin
         if (clr_status) begin
            r_ovf_count <= w_drop ? 8'd1 : 8'd0;
         end else if (w_drop && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
         end
         if (clr_status) begin
            r_ferr_count <= r_frame_err ? 8'd1 : 8'd0;
         end else if (r_frame_err && (r_ferr_count != 8'hFF)) begin
            r_ferr_count <= r_ferr_count + 8'd1;
         end
      end
   end

   assign ovf_count  = r_ovf_count;
   assign ferr_count = r_ferr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_rx_deserializer.sv
// ============================================================================
// Module  : tb_spi_rx_deserializer
// Purpose : Self-checking bench for spi_rx_deserializer with a queue model of
//           the receive FIFO; exercises SPI_RX_STATUS_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_rx_deserializer;

   localparam int SW = 32;
   localparam int FD = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CEB;
   logic        SCLK;
   logic        DATA;
   logic        out_ready;
   logic        clr_status;
   logic        out_valid;
   logic        busy;
   logic        frame_err;
   logic        overflow;
   logic [31:0] out_data;
`ifdef SPI_RX_STATUS_EN
   logic [7:0]  ovf_count;
   logic [7:0]  ferr_count;
`endif

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          rise_cyc;
   int          lat_seen;
   int          ferr_hi;
   int          busy_hi;
   bit          pop_at_push = 1'b0;
   logic [31:0] q[$];
   bit          m_ovf;

   always #5 CLK = ~CLK;

   spi_rx_deserializer #(
      .sword       (SW),
      .fifo_depth  (FD),
      .sync_stages (2)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CEB        (CEB),
      .SCLK       (SCLK),
      .DATA       (DATA),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .clr_status (clr_status)
`ifdef SPI_RX_STATUS_EN
      ,
      .ovf_count  (ovf_count),
      .ferr_count (ferr_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CLK period; observe outputs on the falling edge.
   task automatic tick();
      @(negedge CLK);
      cyc++;
      if (out_valid && lat_seen < 0 && rise_cyc >= 0) lat_seen = cyc - rise_cyc;
      if (frame_err) ferr_hi++;
      if (busy) busy_hi++;
      if (pop_at_push && rise_cyc >= 0) begin
         if (cyc == rise_cyc + 3) out_ready = 1'b1;
         else if (cyc == rise_cyc + 4) out_ready = 1'b0;
      end
   endtask

   // SCLK period of 4 CLK (2 low, 2 high), MSB first.
   task automatic send(input logic [31:0] w, input int nbits, input bit end_frame);
      rise_cyc = -1;
      lat_seen = -1;
      ferr_hi  = 0;
      busy_hi  = 0;
      CEB = 1'b0;
      tick(); tick();
      for (int i = 0; i < nbits; i++) begin
         DATA = w[31-i];
         SCLK = 1'b0;
         tick(); tick();
         SCLK = 1'b1;
         if (i == SW - 1) rise_cyc = cyc;
         tick(); tick();
      end
      if (end_frame) begin
         SCLK = 1'b0;
         tick(); tick();
         CEB  = 1'b1;
         DATA = 1'b0;
         repeat (4) tick();
      end
   endtask

   task automatic mpush(input logic [31:0] w);
      if (q.size() < FD) q.push_back(w);
      else m_ovf = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = q.size();
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_data"}, out_data, q.pop_front());
         tick();
      end
      out_ready = 1'b0;
      check({tag, "_empty"}, out_valid, 0);
   endtask

   task automatic clear_status();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      m_ovf = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] w;
      int          n;
      RST = 1'b1; CEB = 1'b1; SCLK = 1'b0; DATA = 1'b0;
      out_ready = 1'b0; clr_status = 1'b0; m_ovf = 1'b0;
      rise_cyc = -1; lat_seen = -1;
      repeat (3) tick();
      RST = 1'b0;
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);

      // Single frame with latency measured from the last SCLK rise drive.
      send(32'hA5C3_0F81, SW, 1'b1);
      mpush(32'hA5C3_0F81);
      check("lat_valid", lat_seen, 4);
      check("f1_ferr", ferr_hi, 0);
      check("f1_busy_seen", busy_hi > 0, 1);
      check("f1_busy_end", busy, 0);
      drain("f1");

      // Aborted frame after 17 bits, then a good frame.
      send(32'h1234_5678, 17, 1'b1);
      check("abort_pulse", ferr_hi, 1);
      check("abort_empty", out_valid, 0);
      check("abort_busy", busy, 0);
      send(32'h1234_5678, SW, 1'b1);
      mpush(32'h1234_5678);
      check("post_abort_ferr", ferr_hi, 0);
      drain("f2");

      // Overflow with the consumer stalled.
      for (int i = 1; i <= 5; i++) begin
         send(32'(i), SW, 1'b1);
         mpush(32'(i));
      end
      check("ovf_set", overflow, m_ovf);
      drain("ovf");
      check("ovf_sticky", overflow, 1);

      // Reset in the middle of a frame with a word queued.
      send(32'h0000_0077, SW, 1'b1);
      send(32'hFFFF_FFFF, 10, 1'b0);
      check("mid_busy", busy, 1);
      check("mid_valid", out_valid, 1);
      RST = 1'b1; CEB = 1'b1; SCLK = 1'b0; DATA = 1'b0;
      tick();
      check("mrst_valid", out_valid, 0);
      check("mrst_data", out_data, 0);
      check("mrst_busy", busy, 0);
      check("mrst_ferr", frame_err, 0);
      check("mrst_ovf", overflow, 0);
      RST = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      repeat (4) tick();
      send(32'hDEAD_BEEF, SW, 1'b1);
      mpush(32'hDEAD_BEEF);
      drain("post_rst");

      // Full FIFO with a pop in the PUSH cycle of the fifth word.
      for (int i = 0; i < FD; i++) begin
         send(32'hA + 32'(i), SW, 1'b1);
         mpush(32'hA + 32'(i));
      end
      pop_at_push = 1'b1;
      send(32'h9, SW, 1'b1);
      pop_at_push = 1'b0;
      void'(q.pop_front());
      q.push_back(32'h9);
      check("full_pop_ovf", overflow, 0);
      drain("full_pop");

      // Randomized bursts against the queue model.
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            w = $urandom;
            send(w, SW, 1'b1);
            mpush(w);
         end
         check("rnd_ovf", overflow, m_ovf);
         drain("rnd");
         clear_status();
         check("rnd_clr", overflow, 0);
      end

`ifdef SPI_RX_STATUS_EN
      for (int i = 0; i < 5; i++) begin
         send(32'h100 + 32'(i), SW, 1'b1);
         mpush(32'h100 + 32'(i));
      end
      check("cnt_ovf", ovf_count, 1);
      for (int i = 0; i < 300; i++) send(32'h8000_0000, 1, 1'b1);
      check("cnt_ferr_sat", ferr_count, 255);
      check("cnt_ovf_flag", overflow, 1);
      clear_status();
      check("cnt_ferr_clr", ferr_count, 0);
      check("cnt_ovf_clr", ovf_count, 0);
      check("cnt_flag_clr", overflow, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_rx_deserializer.md
Name: spi_rx_deserializer

Overview:
- Downstream receiver for the SPI stream emitted by the AXI-lite-to-SPI serializer.
- Samples CEB/SCLK/DATA in the CLK domain and assembles MSB-first words of sword bits.
- Buffers completed words in a small FIFO and presents them on a valid/ready stream, for example to a peripheral register or a loopback checker.
- Flags truncated frames and FIFO overflow.

Parameters:
- sword, 32, word width in bits; also the frame length in SCLK cycles.
- fifo_depth, 4, number of FIFO entries; must be a power of two, minimum 2.
- sync_stages, 2, synchronizer flops on CEB, SCLK and DATA; minimum 2.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- CEB  input  1  SPI chip enable, active-low; frames one word.
- SCLK  input  1  SPI clock; free-running is allowed.
- DATA  input  1  SPI serial data, MSB first; content is don't-care (may be z) while CEB is high.
- out_valid  output  1  FIFO head word is valid.
- out_ready  input  1  consumer accepts the head word.
- out_data  output  sword  FIFO head word.
- busy  output  1  a frame is in progress.
- frame_err  output  1  one-cycle pulse on an aborted frame.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- clr_status  input  1  clears overflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - CLK is the clock port; RST is the reset port, sampled on CLK rising edge, active level 1.
- Reset values:
  - out_valid=0, out_data=0, busy=0, frame_err=0, overflow=0.
  - FIFO empty; bit counter 0; shift register 0; state IDLE.
  - Synchronizer flops reset to CEB=1, SCLK=0, DATA=0.
- Synchronization and sampling:
  - CEB, SCLK and DATA each pass through sync_stages flops.
  - sclk_rise = synced SCLK is 1 and its previous synced value is 0.
  - Sampling requirement: SCLK high and low phases are each at least 2 CLK periods. This is met when the upstream numbit_divisor >= 3.
- FSM states: IDLE, SHIFT, PUSH.
  - IDLE, synced CEB=0: go to SHIFT; counter=0; busy=1 from the next cycle.
  - SHIFT, sclk_rise with CEB=0: shreg <= {shreg[sword-2:0], DATA_sync}; counter++.
  - SHIFT, counter reaches sword on a sample: go to PUSH on the next edge.
  - SHIFT, synced CEB=1 before sword bits: frame_err pulses for 1 cycle, partial word is discarded, go to IDLE.
  - PUSH: write shreg to FIFO if not full; otherwise drop the word and set overflow=1. Go to IDLE and deassert busy.
  - IDLE after PUSH while CEB is still low: wait for CEB=1 and then CEB=0 again before starting a new frame. Extra SCLK edges are ignored.
- Latency: the CLK edge that samples the last bit is cycle T.
  - PUSH occurs in cycle T+1.
  - out_valid is 1 in cycle T+2 if the FIFO was previously empty.
- FIFO:
  - out_data is the head entry, registered from RAM or regs.
  - Pop happens when out_valid and out_ready are both 1; the next word is visible on the following cycle.
  - Pointers are log2(fifo_depth)+1 bits and wrap naturally.
  - full = pointer MSBs differ and the remaining bits are equal.
  - Push and pop in the same cycle when full: the pop frees a slot and the push is accepted; no overflow.
  - Push and pop in the same cycle when empty: no bypass; the word appears the following cycle.
  - out_ready while out_valid=0: no effect.
- overflow:
  - Stays set until clr_status=1.
  - If clr_status and a new overflow event occur in the same cycle, overflow stays 1.
- Reset mid-frame: everything returns to reset values and the partial word is lost.

Optional Feature:
- Macro: SPI_RX_STATUS_EN.
- Defined:
  - Adds output ports ovf_count[7:0] and ferr_count[7:0].
  - Both are 8-bit counters, reset to 0, that saturate at 255.
  - ovf_count increments on each dropped word; ferr_count increments on each frame_err pulse.
  - Both clear when clr_status=1; if clr_status and an event occur in the same cycle, the count becomes 1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding localparams (IDLE=0, SHIFT=1, PUSH=2);
  - the clogb2 helper;
  - SPI_SYNC_RESET_CEB=1'b1.
- One sub-module: spi_rx_fifo (parameters sword and fifo_depth; ports push, push_data, pop, head_data, full, empty).
- The synchronizers and FSM stay in the top module.

Test Plan:
- Single frame, sword=32, 4-CLK SCLK period, DATA=0xA5C3_0F81 MSB first -> out_valid rises exactly 2 CLK after the last-bit sample; out_data=0xA5C30F81; frame_err=0.
- CEB rises after 17 bits -> frame_err is a single-cycle pulse, FIFO stays empty, busy returns to 0; the next full frame 0x12345678 is received correctly.
- out_ready=0, 5 frames 0x1,0x2,0x3,0x4,0x5 with fifo_depth=4 -> FIFO holds 0x1..0x4 and overflow=1. Drain with out_ready=1 -> 0x1,0x2,0x3,0x4 in order, then out_valid=0.
- FIFO full with out_ready=1 asserted in the PUSH cycle of frame 0x9 -> no overflow; 0x9 is delivered after 3 further pops.
- RST=1 asserted mid-frame after 10 bits -> all outputs at reset values on the next cycle; a subsequent frame 0xDEADBEEF is received intact.
- With SPI_RX_STATUS_EN defined: 300 aborted frames -> ferr_count=255; clr_status pulse -> ferr_count=0 and overflow=0.
